// File: rtl/mem_wb_stage_pkg.sv
// Shared core types for the MEM/WB stage: datapath widths, writeback source
// select and the load funct3 encodings.
package mem_wb_stage_pkg;

   localparam int XLEN           = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-stage result bundle handed to the MEM/WB register; the MEM stage drives
// it through the master modport, the WB stage consumes it as slave.
interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic                      mem_valid;
   logic                      mem_reg_write;
   logic [REG_ADDR_WIDTH-1:0] mem_rd;
   wb_sel_t                   mem_wb_sel;
   logic [2:0]                mem_funct3;
   logic [XLEN-1:0]           mem_alu_result;
   logic [XLEN-1:0]           mem_pc_plus4;

   modport master (
      output mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_funct3, mem_alu_result, mem_pc_plus4
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_funct3, mem_alu_result, mem_pc_plus4
   );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load data formatter: picks the byte/half/word at the address offset,
// sign- or zero-extends it, and flags halfword/word accesses that are misaligned.
module mem_wb_stage_load_align
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = word[{offset, 3'b000} +: 8];
      half_sel   = offset[1] ? word[31:16] : word[15:0];
      data       = '0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH: begin
            data       = {{(XLEN-16){half_sel[15]}}, half_sel};
            misaligned = offset[0];
         end
         F3_LHU: begin
            data       = {{(XLEN-16){1'b0}}, half_sel};
            misaligned = offset[0];
         end
         F3_LW: begin
            data       = word;
            misaligned = (offset != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback formatting: selects the regfile write
// value, gates the write enable, reports misaligned loads and counts retirements.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int CNT_W = 64
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   mem_wb_stage_if.slave             mem,
   input  logic [XLEN-1:0]           dmem_rdata,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [XLEN-1:0]           wb_write_data,
   output logic                      wb_wr_en,
   output logic                      wb_valid,
   output logic                      load_misaligned,
   output logic [CNT_W-1:0]          instret
);

   logic                      valid_q;
   logic                      reg_write_q;
   logic [REG_ADDR_WIDTH-1:0] rd_q;
   wb_sel_t                   wb_sel_q;
   logic [2:0]                funct3_q;
   logic [XLEN-1:0]           alu_q;
   logic [XLEN-1:0]           pc4_q;
   logic [XLEN-1:0]           hold_q;
   logic                      first_q;
   logic [CNT_W-1:0]          instret_q;

   logic [XLEN-1:0]           load_word;
   logic [XLEN-1:0]           load_data;
   logic                      align_mis;
   logic                      misaligned;
   logic                      retire;

   // dmem data is only on the bus during the first WB cycle; afterwards the copy in hold_q is used
   assign load_word = first_q ? dmem_rdata : hold_q;

   mem_wb_stage_load_align u_align (
      .funct3     (funct3_q),
      .offset     (alu_q[1:0]),
      .word       (load_word),
      .data       (load_data),
      .misaligned (align_mis)
   );

   assign misaligned = (wb_sel_q == WB_LOAD) & align_mis;
   assign retire     = valid_q & ~stall & ~misaligned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         wb_sel_q    <= WB_ALU;
         funct3_q    <= '0;
         alu_q       <= '0;
         pc4_q       <= '0;
         hold_q      <= '0;
         first_q     <= 1'b0;
         instret_q   <= '0;
      end else begin
         if (first_q) begin
            hold_q <= dmem_rdata;
         end
         // flush only discards the incoming slot; the held instruction still commits this cycle
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
         if (flush) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
         end else if (stall) begin
            first_q <= 1'b0;
         end else begin
            valid_q     <= mem.mem_valid;
            first_q     <= mem.mem_valid;
            reg_write_q <= mem.mem_reg_write;
            rd_q        <= mem.mem_rd;
            wb_sel_q    <= mem.mem_wb_sel;
            funct3_q    <= mem.mem_funct3;
            alu_q       <= mem.mem_alu_result;
            pc4_q       <= mem.mem_pc_plus4;
         end
      end
   end

   always_comb begin
      wb_write_data = '0;
      if (valid_q) begin
         case (wb_sel_q)
            WB_ALU:  wb_write_data = alu_q;
            WB_LOAD: wb_write_data = load_data;
            WB_PC4:  wb_write_data = pc4_q;
            default: wb_write_data = '0;
         endcase
      end
   end

   assign wb_rd           = rd_q;
   assign wb_valid        = valid_q;
   assign wb_wr_en        = valid_q & reg_write_q & (rd_q != '0) & ~misaligned & ~stall;
   assign load_misaligned = valid_q & misaligned;
   assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus randomized traffic,
// compared against a transaction-level model of the instruction held in WB.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      stall;
   logic                      flush;
   logic [XLEN-1:0]           dmem_rdata;
   logic [REG_ADDR_WIDTH-1:0] wb_rd;
   logic [XLEN-1:0]           wb_write_data;
   logic                      wb_wr_en;
   logic                      wb_valid;
   logic                      load_misaligned;
   logic [63:0]               instret;

   int checkCount = 0;
   int errorCount = 0;

   // Model of the instruction currently in WB, plus the retired count
   bit              mValid;
   bit              mRegWrite;
   bit              mHaveWord;
   int unsigned     mRd, mSel, mF3, mAlu, mPc4, mWord;
   longint unsigned mInstret;

   mem_wb_stage_if memBus();

   mem_wb_stage #(.CNT_W(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .mem             (memBus),
      .dmem_rdata      (dmem_rdata),
      .wb_rd           (wb_rd),
      .wb_write_data   (wb_write_data),
      .wb_wr_en        (wb_wr_en),
      .wb_valid        (wb_valid),
      .load_misaligned (load_misaligned),
      .instret         (instret)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic void loadResult(input int unsigned f3, input int unsigned word, input int unsigned off,
                                      output int unsigned data, output bit mis);
      int unsigned b;
      int unsigned h;
      b    = (word >> (8 * off)) & 32'hFF;
      h    = (word >> (16 * (off / 2))) & 32'hFFFF;
      data = 0;
      mis  = 1'b0;
      case (f3)
         0: data = (b >= 128) ? (b | 32'hFFFFFF00) : b;
         4: data = b;
         1: begin data = (h >= 32768) ? (h | 32'hFFFF0000) : h; mis = (off % 2) != 0; end
         5: begin data = h; mis = (off % 2) != 0; end
         2: begin data = word; mis = off != 0; end
         default: ;
      endcase
   endfunction

   task automatic modelReset();
      mValid = 0; mRegWrite = 0; mHaveWord = 0;
      mRd = 0; mSel = 0; mF3 = 0; mAlu = 0; mPc4 = 0; mWord = 0;
      mInstret = 0;
   endtask

   function automatic bit modelMisaligned();
      int unsigned ld;
      bit          mis;
      loadResult(mF3, mHaveWord ? mWord : dmem_rdata, mAlu % 4, ld, mis);
      return mValid && (mSel == 1) && mis;
   endfunction

   task automatic applyStimulus(input bit st, input bit fl, input bit mv, input bit rw,
                                input int unsigned rd, input int unsigned sel, input int unsigned f3,
                                input int unsigned alu, input int unsigned pc4, input int unsigned dm);
      @(negedge clk);
      stall                 = st;
      flush                 = fl;
      memBus.mem_valid      = mv;
      memBus.mem_reg_write  = rw;
      memBus.mem_rd         = REG_ADDR_WIDTH'(rd);
      memBus.mem_wb_sel     = wb_sel_t'(sel[1:0]);
      memBus.mem_funct3     = f3[2:0];
      memBus.mem_alu_result = alu;
      memBus.mem_pc_plus4   = pc4;
      dmem_rdata            = dm;
      #1;
   endtask

   task automatic checkModel();
      int unsigned ld;
      int unsigned expData;
      bit          mis;
      bit          expMis;
      bit          expWe;
      loadResult(mF3, mHaveWord ? mWord : dmem_rdata, mAlu % 4, ld, mis);
      expMis = modelMisaligned();
      if (!mValid)        expData = 0;
      else if (mSel == 0) expData = mAlu;
      else if (mSel == 1) expData = ld;
      else                expData = mPc4;
      expWe = mValid && mRegWrite && (mRd != 0) && !expMis && !stall;
      checkOutput("wb_valid", 64'(wb_valid), 64'(mValid));
      checkOutput("wb_wr_en", 64'(wb_wr_en), 64'(expWe));
      checkOutput("wb_write_data", 64'(wb_write_data), 64'(expData));
      checkOutput("load_misaligned", 64'(load_misaligned), 64'(expMis));
      checkOutput("instret", instret, mInstret);
      if (mValid) checkOutput("wb_rd", 64'(wb_rd), 64'(mRd));
   endtask

   // Advance the model across the rising edge using the inputs applied this cycle
   task automatic tick();
      bit misNow;
      @(posedge clk);
      misNow = modelMisaligned();
      if (mValid && !stall && !misNow) mInstret++;
      if (mValid && !mHaveWord) begin
         mWord     = dmem_rdata;
         mHaveWord = 1;
      end
      if (flush) begin
         mValid = 0;
      end else if (!stall) begin
         mValid    = memBus.mem_valid;
         mRegWrite = memBus.mem_reg_write;
         mRd       = 32'(memBus.mem_rd);
         mSel      = 32'(memBus.mem_wb_sel);
         mF3       = 32'(memBus.mem_funct3);
         mAlu      = memBus.mem_alu_result;
         mPc4      = memBus.mem_pc_plus4;
         mHaveWord = 0;
      end
   endtask

   task automatic bubbleCycle(input bit st, input int unsigned dm);
      applyStimulus(st, 0, 0, 0, 0, 0, 0, 0, 0, dm);
      checkModel();
   endtask

   int unsigned     ldF3[4]  = '{0, 4, 1, 2};
   int unsigned     ldOff[4] = '{3, 3, 2, 0};
   int unsigned     ldExp[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};
   int unsigned     loadF3s[5] = '{0, 1, 2, 4, 5};
   longint unsigned savedRet;
   int unsigned     rSel, rF3, rAlu;

   initial begin
      reset                 = 1'b1;
      stall                 = 1'b0;
      flush                 = 1'b0;
      dmem_rdata            = '0;
      memBus.mem_valid      = 1'b0;
      memBus.mem_reg_write  = 1'b0;
      memBus.mem_rd         = '0;
      memBus.mem_wb_sel     = WB_ALU;
      memBus.mem_funct3     = '0;
      memBus.mem_alu_result = '0;
      memBus.mem_pc_plus4   = '0;
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", 64'(wb_valid), 64'h0);
      checkOutput("rst_wr_en", 64'(wb_wr_en), 64'h0);
      checkOutput("rst_data", 64'(wb_write_data), 64'h0);
      checkOutput("rst_misaligned", 64'(load_misaligned), 64'h0);
      checkOutput("rst_instret", instret, 64'h0);
      @(negedge clk);
      reset = 1'b0;

      // ALU writeback
      applyStimulus(0, 0, 1, 1, 5, 0, 0, 32'h1234, 32'h4, 0);
      checkModel(); tick();
      bubbleCycle(0, 0);
      checkOutput("alu_wr_en", 64'(wb_wr_en), 64'h1);
      checkOutput("alu_rd", 64'(wb_rd), 64'h5);
      checkOutput("alu_data", 64'(wb_write_data), 64'h1234);
      tick();
      bubbleCycle(0, 0);
      checkOutput("alu_instret", instret, 64'h1);
      tick();

      // Load formatting of dmem word 0x80FF7F01
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 1, 10 + i, 1, ldF3[i], 32'h1000 + ldOff[i], 0, 0);
         checkModel(); tick();
         bubbleCycle(0, 32'h80FF7F01);
         checkOutput($sformatf("load%0d_data", i), 64'(wb_write_data), 64'(ldExp[i]));
         checkOutput($sformatf("load%0d_wr_en", i), 64'(wb_wr_en), 64'h1);
         tick();
      end

      // Misaligned word load
      savedRet = mInstret;
      applyStimulus(0, 0, 1, 1, 7, 1, 2, 32'h1002, 0, 0);
      checkModel(); tick();
      bubbleCycle(0, 32'h80FF7F01);
      checkOutput("mis_flag", 64'(load_misaligned), 64'h1);
      checkOutput("mis_wr_en", 64'(wb_wr_en), 64'h0);
      tick();
      bubbleCycle(0, 0);
      checkOutput("mis_instret", instret, savedRet);
      tick();

      // Stalled load keeps its first-cycle data
      applyStimulus(0, 0, 1, 1, 8, 1, 2, 32'h2000, 0, 0);
      checkModel(); tick();
      applyStimulus(1, 0, 1, 1, 9, 0, 0, 32'h55, 0, 32'h80FF7F01);
      checkModel();
      checkOutput("stall0_data", 64'(wb_write_data), 64'h80FF7F01);
      checkOutput("stall0_wr_en", 64'(wb_wr_en), 64'h0);
      tick();
      for (int i = 1; i < 3; i++) begin
         applyStimulus(1, 0, 1, 1, 9, 0, 0, 32'h55, 0, 32'hDEAD);
         checkModel();
         checkOutput($sformatf("stall%0d_data", i), 64'(wb_write_data), 64'h80FF7F01);
         checkOutput($sformatf("stall%0d_wr_en", i), 64'(wb_wr_en), 64'h0);
         tick();
      end
      bubbleCycle(0, 32'hDEAD);
      checkOutput("release_data", 64'(wb_write_data), 64'h80FF7F01);
      checkOutput("release_wr_en", 64'(wb_wr_en), 64'h1);
      tick();
      bubbleCycle(0, 32'hDEAD);
      checkOutput("after_release_wr_en", 64'(wb_wr_en), 64'h0);
      tick();

      // rd=0 retires without writing
      savedRet = mInstret;
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 32'hABCD, 0, 0);
      checkModel(); tick();
      bubbleCycle(0, 0);
      checkOutput("rd0_wr_en", 64'(wb_wr_en), 64'h0);
      checkOutput("rd0_valid", 64'(wb_valid), 64'h1);
      tick();
      bubbleCycle(0, 0);
      checkOutput("rd0_instret", instret, savedRet + 1);
      tick();

      // Flush wins over stall
      applyStimulus(0, 0, 1, 1, 3, 0, 0, 32'h77, 0, 0);
      checkModel(); tick();
      applyStimulus(1, 1, 1, 1, 4, 0, 0, 32'h88, 0, 0);
      checkModel(); tick();
      bubbleCycle(0, 0);
      checkOutput("flush_stall_valid", 64'(wb_valid), 64'h0);
      tick();

      // Asynchronous reset in the middle of a stall
      applyStimulus(0, 0, 1, 1, 6, 0, 0, 32'h99, 0, 0);
      checkModel(); tick();
      bubbleCycle(1, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("areset_valid", 64'(wb_valid), 64'h0);
      checkOutput("areset_wr_en", 64'(wb_wr_en), 64'h0);
      checkOutput("areset_data", 64'(wb_write_data), 64'h0);
      checkOutput("areset_instret", instret, 64'h0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rSel = $urandom_range(0, 2);
         rF3  = (rSel == 1) ? loadF3s[$urandom_range(0, 4)] : $urandom_range(0, 7);
         rAlu = $urandom;
         if ($urandom_range(0, 1) == 0) rAlu = rAlu & 32'hFFFFFFFC;
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 31), rSel, rF3, rAlu, $urandom, $urandom);
         checkModel();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
